ram8_seq: RTL and testbench

- Clocked 8-word x WIDTH-bit register bank; consumes the one-hot, address-steered load path produced by the 8-way 16-bit demultiplexer stage.
- Internally decodes `address` into per-word write enables and muxes read data out through a registered read port.
- Adds a hardware clear sweep (reset or `clr` command) with a `busy` flag, so downstream logic never reads uninitialised words.

---
 rtl/ram8_seq.sv | 119 +++++++++++
 tb/tb_ram8_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram8_seq.sv
// ram8_seq: 8-word x WIDTH-bit register bank with a registered read port
// and a hardware clear sweep.
//
// Ports:
//   clk       - system clock, all state changes on the rising edge
//   rst_n     - synchronous active-low reset; starts a clear sweep
//   in        - write data
//   address   - word select for both write and read (0..7)
//   load      - write strobe, mem[address] <= in when accepted
//   rd_en     - read request for mem[address]
//   clr       - clear command, zeroes all words through the sweep
//   busy      - high while the clear sweep runs; commands ignored then
//   out       - registered read data, holds when no read is accepted
//   out_valid - high for one cycle after an accepted read
module ram8_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  input  logic             rd_en,
  input  logic             clr,
  output logic             busy,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [2:0]       clr_ptr_r;
  logic [2:0]       clr_ptr_nxt_s;
  logic             wr_en_s;
  logic [2:0]       wr_addr_s;
  logic [WIDTH-1:0] wr_data_s;
  logic             rd_acc_s;
  logic [WIDTH-1:0] rd_data_s;
  logic [WIDTH-1:0] mem_r [0:7];

  // Next-state, write-port steering and read-data selection.
  always_comb begin
    state_nxt_s   = state_r;
    clr_ptr_nxt_s = clr_ptr_r;
    wr_en_s       = 1'b0;
    wr_addr_s     = address;
    wr_data_s     = in;
    rd_acc_s      = 1'b0;
    rd_data_s     = mem_r[address];
    case (state_r)
      IDLE: begin
        if (clr) begin
          // clr wins: same-cycle load and rd_en are dropped.
          state_nxt_s   = CLEAR;
          clr_ptr_nxt_s = 3'd0;
        end else begin
          wr_en_s  = load;
          rd_acc_s = rd_en;
          // Read and write share one address, so a simultaneous
          // load always hits the word being read: forward the new data.
          if (load && rd_en) begin
            rd_data_s = in;
          end else begin
            rd_data_s = mem_r[address];
          end
        end
      end
      CLEAR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = clr_ptr_r;
        wr_data_s = {WIDTH{1'b0}};
        if (clr_ptr_r == 3'd7) begin
          state_nxt_s   = IDLE;
          clr_ptr_nxt_s = 3'd0;
        end else begin
          clr_ptr_nxt_s = clr_ptr_r + 3'd1;
        end
      end
      default: begin
        state_nxt_s   = CLEAR;
        clr_ptr_nxt_s = 3'd0;
      end
    endcase
  end

  // Control state, busy flag and registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= CLEAR;
      clr_ptr_r <= 3'd0;
      busy      <= 1'b1;
      out       <= {WIDTH{1'b0}};
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      clr_ptr_r <= clr_ptr_nxt_s;
      busy      <= (state_nxt_s == CLEAR);
      out_valid <= rd_acc_s;
      if (rd_acc_s) begin
        out <= rd_data_s;
      end else begin
        out <= out;
      end
    end
  end

  // Storage array: no direct reset, zeroed only by the sweep.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_ram8_seq.sv
// Directed self-checking bench for ram8_seq.
module tb_ram8_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = 16'h0000;
  logic [2:0]  address = 3'd0;
  logic        load = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr = 1'b0;
  logic        busy;
  logic [15:0] out;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  ram8_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .address(address), .load(load),
    .rd_en(rd_en), .clr(clr), .busy(busy), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    address = a; in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic read_all_expect(input logic [15:0] exp_word, input string tag);
    for (int i = 0; i < 8; i++) begin
      address = i[2:0]; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      checks++;
      if (out !== exp_word || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s word %0d: got out=%h valid=%b expected out=%h valid=1",
                 tag, i, out, out_valid, exp_word);
      end
    end
  endtask

  // Count edges until busy falls, bounded; expect exactly n.
  task automatic expect_busy_for(input int n, input string tag);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != n || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy length: got %0d edges (busy=%b) expected %0d", tag, cnt, busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b out=%h valid=%b expected 1 0000 0",
               busy, out, out_valid);
    end
    rst_n = 1'b1;
    expect_busy_for(8, "reset_sweep");
    read_all_expect(16'h0000, "reset_read");
  endtask

  task automatic test_write_read();
    write_word(3'd3, 16'hA5A5);
    write_word(3'd7, 16'h1234);
    rd_en = 1'b1; address = 3'd3;
    tick();
    checks++;
    if (out !== 16'hA5A5 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_read3: got %h valid=%b expected a5a5 valid=1", out, out_valid);
    end
    address = 3'd7;
    tick();
    checks++;
    if (out !== 16'h1234 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_read7: got %h valid=%b expected 1234 valid=1", out, out_valid);
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (out !== 16'h1234 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_hold: got %h valid=%b expected 1234 valid=0", out, out_valid);
    end
    address = 3'd0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (out !== 16'h0000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL other_word0: got %h valid=%b expected 0000 valid=1", out, out_valid);
    end
  endtask

  task automatic test_bypass();
    write_word(3'd5, 16'h0001);
    address = 3'd5; in = 16'hBEEF; load = 1'b1; rd_en = 1'b1;
    tick();
    load = 1'b0; rd_en = 1'b0;
    checks++;
    if (out !== 16'hBEEF || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bypass: got %h valid=%b expected beef valid=1", out, out_valid);
    end
    address = 3'd0; rd_en = 1'b1;
    tick();
    address = 3'd5;
    tick();
    rd_en = 1'b0;
    checks++;
    if (out !== 16'hBEEF || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bypass_readback: got %h valid=%b expected beef", out, out_valid);
    end
  endtask

  task automatic test_clear_cmd();
    for (int i = 0; i < 8; i++) write_word(i[2:0], 16'hFFFF);
    read_all_expect(16'hFFFF, "fill_read");
    clr = 1'b1; load = 1'b1; address = 3'd2; in = 16'h5555;
    tick();
    clr = 1'b0; load = 1'b0;
    rd_en = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || out !== 16'hFFFF) begin
        errors++;
        $display("FAIL clr_busy cycle %0d: got busy=%b valid=%b out=%h expected 1 0 ffff",
                 n, busy, out_valid, out);
      end
      tick();
    end
    rd_en = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_end: got busy=%b valid=%b expected 0 0", busy, out_valid);
    end
    read_all_expect(16'h0000, "clr_read");
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < 8; i++) write_word(i[2:0], 16'h7777);
    address = 3'd6; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    rst_n = 1'b0; load = 1'b1; address = 3'd6; in = 16'h1111;
    tick();
    load = 1'b0;
    checks++;
    if (busy !== 1'b1 || out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: got busy=%b out=%h valid=%b expected 1 0000 0",
               busy, out, out_valid);
    end
    rst_n = 1'b1;
    expect_busy_for(8, "mid_reset_sweep");
    read_all_expect(16'h0000, "mid_reset_read");
  endtask

  task automatic test_clr_during_sweep();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      clr = (n == 3);
      tick();
      clr = 1'b0;
      checks++;
      if (busy !== (n < 8)) begin
        errors++;
        $display("FAIL no_restart edge %0d: got busy=%b expected %b", n, busy, (n < 8));
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_restart_after: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear_cmd();
    test_reset_mid_sweep();
    test_clr_during_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
